cnn_mem_bank: RTL



---
 rtl/cnn_mem_bank.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cnn_mem_bank.sv
// Avalon-MM staging memory: the HPS fills banked RAM through a pointer/data register pair,
// and the CNN datapath reads any bank through a dedicated 1-cycle-latency port.
module cnn_mem_bank #(
    parameter int DEPTH     = 1024,
    parameter int NUM_BANKS = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          chipselect,
    input  logic          write,
    input  logic          read,
    input  logic [2:0]    address,
    input  logic [7:0]    writedata,
    output logic [7:0]    readdata,
    input  logic          cnn_rd_en,
    input  logic [BW-1:0] cnn_bank,
    input  logic [AW-1:0] cnn_addr,
    output logic [7:0]    cnn_rd_data,
    output logic          cnn_rd_valid,
    output logic          loaded
);

    logic [7:0]    mem [NUM_BANKS][DEPTH];
    logic [AW-1:0] ptr;
    logic [BW-1:0] bank;
    logic          ovf;

    logic          hostWr;
    logic          hostRd;
    logic          dataWr;
    logic          dataRd;
    logic [15:0]   ptrWide;
    logic [AW-1:0] ptrLoNext;
    logic [AW-1:0] ptrHiNext;
    logic          bankWrOk;
    logic          cnnBankOk;
    logic [BW-1:0] cnnBankSel;
    logic [7:0]    regRead;

    // A simultaneous read+write is treated as a write only.
    assign hostWr     = chipselect & write;
    assign hostRd     = chipselect & read & ~write;
    assign dataWr     = hostWr && (address == 3'd3) && !loaded;
    assign dataRd     = hostRd && (address == 3'd3);
    assign ptrWide    = 16'(ptr);
    assign bankWrOk   = 32'(writedata) < NUM_BANKS;
    assign cnnBankOk  = 32'(cnn_bank) < NUM_BANKS;
    assign cnnBankSel = cnnBankOk ? cnn_bank : '0;

    generate
        if (AW > 8) begin : g_wide_ptr
            assign ptrLoNext = {ptr[AW-1:8], writedata};
            assign ptrHiNext = {writedata[AW-9:0], ptr[7:0]};
        end else begin : g_byte_ptr
            assign ptrLoNext = writedata[AW-1:0];
            assign ptrHiNext = ptr;
        end
    endgenerate

    always_comb begin
        regRead = 8'h00;
        case (address)
            3'd0:    regRead = {6'b0, ovf, loaded};
            3'd1:    regRead = ptrWide[7:0];
            3'd2:    regRead = ptrWide[15:8];
            3'd3:    regRead = mem[bank][ptr];
            3'd4:    regRead = 8'(bank);
            default: regRead = 8'h00;
        endcase
    end

    // Explicit pointer writes come after the auto-increment so they take priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            bank     <= '0;
            loaded   <= 1'b0;
            ovf      <= 1'b0;
            readdata <= 8'h00;
        end else begin
            readdata <= hostRd ? regRead : 8'h00;
            if (dataWr || dataRd) begin
                if (ptr == AW'(DEPTH - 1)) begin
                    ptr <= '0;
                    ovf <= 1'b1;
                end else begin
                    ptr <= ptr + AW'(1);
                end
            end
            if (hostWr) begin
                case (address)
                    3'd0: begin
                        if (writedata[0]) ptr <= '0;
                        if (writedata[2]) loaded <= 1'b0;
                        else if (writedata[1]) loaded <= 1'b1;
                        if (writedata[3]) ovf <= 1'b0;
                    end
                    3'd1: ptr <= ptrLoNext;
                    3'd2: ptr <= ptrHiNext;
                    3'd4: if (bankWrOk) bank <= writedata[BW-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dataWr) mem[bank][ptr] <= writedata;
    end

    // Non-blocking read of the array gives read-before-write against the host port.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnn_rd_data  <= 8'h00;
            cnn_rd_valid <= 1'b0;
        end else begin
            cnn_rd_valid <= cnn_rd_en;
            if (cnn_rd_en) cnn_rd_data <= cnnBankOk ? mem[cnnBankSel][cnn_addr] : 8'h00;
        end
    end

endmodule
